// File: rtl/unsaved_nios2_cpu_div_cell.sv
// unsaved_nios2_cpu_div_cell
// Multi-cycle radix-2 restoring divider for the Nios II execute path.
// One quotient bit is produced per clock. A divide always takes the same
// number of cycles, even for small or zero operands.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset; has priority over all inputs
//   E_src1       dividend, sampled on an accepted start
//   E_src2       divisor, sampled on an accepted start
//   E_div_start  divide request, accepted only while idle
//   E_div_signed 1 = two's-complement operands, 0 = unsigned
//   A_flush      cancels an in-flight divide; no done is produced
//   div_busy     high while a divide is in progress
//   div_done     one-cycle pulse marking valid results
//   div_quot     quotient, held until the next done
//   div_rem      remainder (sign follows the dividend), held until the next done
//   div_by_zero  divisor was zero, held with the results
module unsaved_nios2_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  input  logic              A_flush,
  output logic              div_busy,
  output logic              div_done,
  output logic [DATA_W-1:0] div_quot,
  output logic [DATA_W-1:0] div_rem,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // r_dvd starts as the dividend magnitude; quotient bits shift in at the LSB
  // as dividend bits shift out of the MSB, so it ends holding the quotient.
  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_dvsr;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_orig;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign_q;
  logic              r_sign_r;
  logic              r_dvsr_zero;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem_out;
  logic              r_by_zero;

  logic              w_accept;
  logic              w_neg1;
  logic              w_neg2;
  logic [DATA_W-1:0] w_mag1;
  logic [DATA_W-1:0] w_mag2;
  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_trial;
  logic              w_trial_ok;
  logic [DATA_W-1:0] w_quot_fix;
  logic [DATA_W-1:0] w_rem_fix;

  assign w_accept = (r_state == S_IDLE) && E_div_start && !A_flush;
  assign w_neg1   = E_div_signed & E_src1[DATA_W-1];
  assign w_neg2   = E_div_signed & E_src2[DATA_W-1];
  // Two's-complement negation truncated to DATA_W: the magnitude of the most
  // negative value is itself, read as unsigned.
  assign w_mag1   = w_neg1 ? ({DATA_W{1'b0}} - E_src1) : E_src1;
  assign w_mag2   = w_neg2 ? ({DATA_W{1'b0}} - E_src2) : E_src2;

  // The shifted partial remainder can reach 2*divisor-1, so the trial
  // subtraction is one bit wider; its MSB is the borrow/sign.
  assign w_rem_sh   = {r_rem, r_dvd[DATA_W-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvsr};
  assign w_trial_ok = ~w_trial[DATA_W];

  assign w_quot_fix = r_sign_q ? ({DATA_W{1'b0}} - r_dvd) : r_dvd;
  assign w_rem_fix  = r_sign_r ? ({DATA_W{1'b0}} - r_rem) : r_rem;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; flush returns to idle from any active state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (A_flush) begin
          w_next = S_IDLE;
        end else if (r_cnt == {CNT_W{1'b0}}) begin
          w_next = S_FIXUP;
        end else begin
          w_next = S_CALC;
        end
      end
      S_FIXUP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvd       <= {DATA_W{1'b0}};
      r_dvsr      <= {DATA_W{1'b0}};
      r_rem       <= {DATA_W{1'b0}};
      r_orig      <= {DATA_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dvsr_zero <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quot      <= {DATA_W{1'b0}};
      r_rem_out   <= {DATA_W{1'b0}};
      r_by_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dvd       <= w_mag1;
            r_dvsr      <= w_mag2;
            r_rem       <= {DATA_W{1'b0}};
            r_orig      <= E_src1;
            r_cnt       <= CNT_W'(DATA_W - 1);
            r_sign_q    <= w_neg1 ^ w_neg2;
            r_sign_r    <= w_neg1;
            r_dvsr_zero <= (E_src2 == {DATA_W{1'b0}});
            r_busy      <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CALC: begin
          if (A_flush) begin
            r_busy <= 1'b0;
          end else begin
            r_rem <= w_trial_ok ? w_trial[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
            r_dvd <= {r_dvd[DATA_W-2:0], w_trial_ok};
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIXUP: begin
          r_busy <= 1'b0;
          if (!A_flush) begin
            r_done <= 1'b1;
            if (r_dvsr_zero) begin
              r_quot    <= {DATA_W{1'b1}};
              r_rem_out <= r_orig;
              r_by_zero <= 1'b1;
            end else begin
              r_quot    <= w_quot_fix;
              r_rem_out <= w_rem_fix;
              r_by_zero <= 1'b0;
            end
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign div_busy    = r_busy;
  assign div_done    = r_done;
  assign div_quot    = r_quot;
  assign div_rem     = r_rem_out;
  assign div_by_zero = r_by_zero;

endmodule

// File: tb/tb_unsaved_nios2_cpu_div_cell.sv
// Self-checking bench for unsaved_nios2_cpu_div_cell. Expected results come
// from an arithmetic reference model, are queued when a divide is started and
// are popped when the divider signals done.
module tb_unsaved_nios2_cpu_div_cell;

  logic        clk;
  logic        reset;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        E_div_start;
  logic        E_div_signed;
  logic        A_flush;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  unsaved_nios2_cpu_div_cell #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_src1       (E_src1),
    .E_src2       (E_src2),
    .E_div_start  (E_div_start),
    .E_div_signed (E_div_signed),
    .A_flush      (A_flush),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_quot     (div_quot),
    .div_rem      (div_rem),
    .div_by_zero  (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: magnitude divide in 64-bit arithmetic, then sign fix-up
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    logic   na, nb;
    longint la, lb, qm, rm;
    logic [63:0] qv, rv;
    logic [31:0] tq, tr;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.bz = 1'b1;
      return e;
    end
    na = s & a[31];
    nb = s & b[31];
    la = longint'({32'd0, a});
    lb = longint'({32'd0, b});
    if (na) la = 64'sd4294967296 - la;
    if (nb) lb = 64'sd4294967296 - lb;
    qm = la / lb;
    rm = la % lb;
    qv = 64'(qm);
    rv = 64'(rm);
    tq = qv[31:0];
    tr = rv[31:0];
    e.q  = (na ^ nb) ? (32'd0 - tq) : tq;
    e.r  = na ? (32'd0 - tr) : tr;
    e.bz = 1'b0;
    return e;
  endfunction

  // Present a start at the current (negedge) point; optionally queue the expectation
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
    E_src1 = a; E_src2 = b; E_div_signed = s; E_div_start = 1'b1;
    if (push) sb.push_back(model(a, b, s));
  endtask

  // Waits (bounded) for done; optionally injects a second start pulse at cycle inj
  task automatic wait_done(input int inj, input logic [31:0] ia, input logic [31:0] ib,
                           output int lat, output int bbad,
                           output logic [31:0] oq, output logic [31:0] orr, output logic obz);
    lat = -1; bbad = 0; oq = 32'd0; orr = 32'd0; obz = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) E_div_start = 1'b0;
      if (inj > 0 && n == inj) begin E_src1 = ia; E_src2 = ib; E_div_start = 1'b1; end
      if (inj > 0 && n == inj + 1) E_div_start = 1'b0;
      if (div_done === 1'b1) begin
        lat = n; oq = div_quot; orr = div_rem; obz = div_by_zero;
        if (div_busy !== 1'b0) bbad++;
        break;
      end else if (div_busy !== 1'b1) begin
        bbad++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if (div_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", div_busy); else pass_cnt++;
    chk_cnt++; if (div_done !== 1'b0) $display("FAIL reset_done got %b want 0", div_done); else pass_cnt++;
    chk_cnt++; if (div_quot !== 32'd0) $display("FAIL reset_quot got %h want 0", div_quot); else pass_cnt++;
    chk_cnt++; if (div_rem !== 32'd0) $display("FAIL reset_rem got %h want 0", div_rem); else pass_cnt++;
    chk_cnt++; if (div_by_zero !== 1'b0) $display("FAIL reset_bz got %b want 0", div_by_zero); else pass_cnt++;
    reset = 1'b0;
  endtask

  // Table-driven single divides: latency, busy window and results for each
  task automatic test_divides(input string tag, input logic [31:0] ta[], input logic [31:0] tb[], input logic ts[]);
    int lat, bbad; logic [31:0] oq, orr; logic obz; exp_t e;
    for (int i = 0; i < ta.size(); i++) begin
      @(negedge clk);
      drive_start(ta[i], tb[i], ts[i], 1'b1);
      wait_done(0, 32'd0, 32'd0, lat, bbad, oq, orr, obz);
      e = sb.pop_front();
      last = e;
      chk_cnt++; if (lat != 34) $display("FAIL %s[%0d]_latency got %0d want 34", tag, i, lat); else pass_cnt++;
      chk_cnt++; if (bbad != 0) $display("FAIL %s[%0d]_busy bad cycles %0d want 0", tag, i, bbad); else pass_cnt++;
      chk_cnt++; if (oq !== e.q) $display("FAIL %s[%0d]_quot got %h want %h", tag, i, oq, e.q); else pass_cnt++;
      chk_cnt++; if (orr !== e.r) $display("FAIL %s[%0d]_rem got %h want %h", tag, i, orr, e.r); else pass_cnt++;
      chk_cnt++; if (obz !== e.bz) $display("FAIL %s[%0d]_bz got %b want %b", tag, i, obz, e.bz); else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    int lat, bbad; logic [31:0] oq, orr; logic obz; exp_t e;
    @(negedge clk);
    drive_start(32'd1000, 32'd33, 1'b0, 1'b1);
    wait_done(5, 32'd77, 32'd5, lat, bbad, oq, orr, obz);
    e = sb.pop_front(); last = e;
    chk_cnt++; if (lat != 34) $display("FAIL ignore_latency got %0d want 34", lat); else pass_cnt++;
    chk_cnt++; if (oq !== e.q) $display("FAIL ignore_quot got %h want %h", oq, e.q); else pass_cnt++;
    chk_cnt++; if (orr !== e.r) $display("FAIL ignore_rem got %h want %h", orr, e.r); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bbad; logic [31:0] oq, orr; logic obz; exp_t e;
    @(negedge clk);
    drive_start(32'hDEAD_BEEF, 32'h0000_1001, 1'b0, 1'b1);
    wait_done(0, 32'd0, 32'd0, lat, bbad, oq, orr, obz);
    e = sb.pop_front();
    chk_cnt++; if (oq !== e.q || lat != 34) $display("FAIL b2b_first quot %h lat %0d want %h lat 34", oq, lat, e.q); else pass_cnt++;
    // Start in the done cycle itself
    drive_start(32'hFFFF_FF00, 32'h0000_0013, 1'b1, 1'b1);
    wait_done(0, 32'd0, 32'd0, lat, bbad, oq, orr, obz);
    e = sb.pop_front(); last = e;
    chk_cnt++; if (lat != 34) $display("FAIL b2b_second_latency got %0d want 34", lat); else pass_cnt++;
    chk_cnt++; if (oq !== e.q) $display("FAIL b2b_second_quot got %h want %h", oq, e.q); else pass_cnt++;
    chk_cnt++; if (orr !== e.r) $display("FAIL b2b_second_rem got %h want %h", orr, e.r); else pass_cnt++;
  endtask

  task automatic test_flush_idle_start();
    int dones = 0, busy_hi = 0;
    @(negedge clk);
    drive_start(32'd50, 32'd5, 1'b0, 1'b0);
    A_flush = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin E_div_start = 1'b0; A_flush = 1'b0; end
      if (div_done === 1'b1) dones++;
      if (div_busy !== 1'b0) busy_hi++;
    end
    chk_cnt++; if (busy_hi != 0) $display("FAIL flush_idle_busy got %0d busy cycles want 0", busy_hi); else pass_cnt++;
    chk_cnt++; if (dones != 0) $display("FAIL flush_idle_done got %0d dones want 0", dones); else pass_cnt++;
  endtask

  task automatic test_flush();
    int dones = 0, busy_hi = 0;
    @(negedge clk);
    drive_start(32'd100, 32'd7, 1'b0, 1'b0);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 1) E_div_start = 1'b0;
      if (n == 10) A_flush = 1'b1;
      if (n == 11) A_flush = 1'b0;
      if (n <= 10 && div_busy !== 1'b1) busy_hi++;
      if (n >= 11 && div_busy !== 1'b0) busy_hi++;
      if (div_done === 1'b1) dones++;
    end
    chk_cnt++; if (busy_hi != 0) $display("FAIL flush_busy got %0d wrong busy cycles want 0", busy_hi); else pass_cnt++;
    chk_cnt++; if (dones != 0) $display("FAIL flush_done got %0d dones want 0", dones); else pass_cnt++;
    chk_cnt++; if (div_quot !== last.q) $display("FAIL flush_quot_held got %h want %h", div_quot, last.q); else pass_cnt++;
    chk_cnt++; if (div_rem !== last.r) $display("FAIL flush_rem_held got %h want %h", div_rem, last.r); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bbad; logic [31:0] oq, orr; logic obz; exp_t e;
    @(negedge clk);
    drive_start(32'h0000_5555, 32'd3, 1'b0, 1'b0);
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      if (n == 1) E_div_start = 1'b0;
      if (n == 20) reset = 1'b1;
    end
    reset = 1'b0;
    chk_cnt++; if (div_busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", div_busy); else pass_cnt++;
    chk_cnt++; if (div_quot !== 32'd0) $display("FAIL rstmid_quot got %h want 0", div_quot); else pass_cnt++;
    chk_cnt++; if (div_rem !== 32'd0) $display("FAIL rstmid_rem got %h want 0", div_rem); else pass_cnt++;
    chk_cnt++; if (div_by_zero !== 1'b0 || div_done !== 1'b0) $display("FAIL rstmid_flags got bz %b done %b want 0 0", div_by_zero, div_done); else pass_cnt++;
    drive_start(32'd100, 32'd7, 1'b0, 1'b1);
    wait_done(0, 32'd0, 32'd0, lat, bbad, oq, orr, obz);
    e = sb.pop_front(); last = e;
    chk_cnt++; if (lat != 34) $display("FAIL rstmid_fresh_latency got %0d want 34", lat); else pass_cnt++;
    chk_cnt++; if (oq !== 32'd14 || orr !== 32'd2) $display("FAIL rstmid_fresh_result got %h/%h want 0000000e/00000002", oq, orr); else pass_cnt++;
  endtask

  initial begin
    logic [31:0] a_tab[];
    logic [31:0] b_tab[];
    logic        s_tab[];
    E_src1 = 32'd0; E_src2 = 32'd0; E_div_start = 1'b0; E_div_signed = 1'b0; A_flush = 1'b0;
    reset = 1'b1;

    test_reset();

    a_tab = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    b_tab = '{32'd7,   32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    s_tab = '{1'b0,    1'b1,          1'b1,          1'b0};
    test_divides("basic", a_tab, b_tab, s_tab);

    a_tab = '{32'h0000_1234, 32'h0000_1234, 32'd9};
    b_tab = '{32'd0,         32'd0,         32'd3};
    s_tab = '{1'b0,          1'b1,          1'b0};
    test_divides("divzero", a_tab, b_tab, s_tab);

    a_tab = new[4]; b_tab = new[4]; s_tab = new[4];
    for (int i = 0; i < 4; i++) begin
      a_tab[i] = $urandom;
      b_tab[i] = $urandom_range(1, 32'h0000_FFFF) ^ ((i % 2 == 1) ? 32'hFFF0_0000 : 32'd0);
      s_tab[i] = 1'(i % 2);
    end
    test_divides("rand", a_tab, b_tab, s_tab);

    test_ignore_start();
    test_back_to_back();
    test_flush_idle_start();
    test_flush();
    test_reset_mid();

    chk_cnt++; if (sb.size() != 0) $display("FAIL scoreboard_empty got %0d left want 0", sb.size()); else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/unsaved_nios2_cpu_div_cell.md
Name: unsaved_nios2_cpu_div_cell

Overview:
Multi-cycle integer divider for the Nios II execute path. It is the inverse-operation companion to the CPU's registered 16x16 multiplier cells. It accepts a 32-bit dividend and divisor from the E stage on a start pulse. It runs a radix-2 restoring divide, one quotient bit per clock, and returns the quotient and remainder together with a one-cycle done pulse. The pipeline stalls on busy and can cancel an in-flight divide with a flush.

Parameters:
DATA_W, 32, operand and result width; iteration count equals DATA_W.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
E_src1  input  DATA_W  dividend; sampled only on an accepted start.
E_src2  input  DATA_W  divisor; sampled only on an accepted start.
E_div_start  input  1  request a divide; accepted only in IDLE.
E_div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
A_flush  input  1  cancel any divide in progress; no done is produced.
div_busy  output  1  high from the cycle after acceptance until done is asserted or flush/reset takes effect.
div_done  output  1  one-cycle pulse; div_quot, div_rem and div_by_zero are valid in this cycle.
div_quot  output  DATA_W  quotient, held until the next done.
div_rem  output  DATA_W  remainder, held until the next done.
div_by_zero  output  1  set with done when the divisor was 0; held with the results.

Behaviour:
- Reset (synchronous, active-high) has priority over every other input. On reset: state returns to IDLE; div_busy=0, div_done=0, div_quot=0, div_rem=0, div_by_zero=0; the iteration counter is cleared.
- States: IDLE, CALC, FIXUP.
- IDLE -> CALC on E_div_start=1 with A_flush=0. At that edge the block latches:
  - |E_src1| and |E_src2| (absolute values only when signed; the magnitude of 0x80000000 is 0x80000000 unsigned);
  - sign_q = sign1 XOR sign2, sign_r = sign1 (both only when signed);
  - the zero-divisor flag;
  - the original E_src1 value.
  - The partial remainder clears and the counter loads DATA_W-1.
- CALC, each cycle:
  - shift {rem, dividend} left by 1;
  - trial = rem - divisor, computed in DATA_W+1 bits;
  - if trial is non-negative, rem = trial and the quotient LSB = 1, else the quotient LSB = 0;
  - the counter decrements. CALC -> FIXUP after the cycle with counter = 0, which makes exactly DATA_W CALC cycles.
- FIXUP, one cycle:
  - div_quot = sign_q ? -q : q;
  - div_rem = sign_r ? -r : r, so the remainder sign follows the dividend;
  - divisor = 0 overrides both: div_quot = all ones, div_rem = original dividend, div_by_zero = 1; otherwise div_by_zero = 0;
  - div_done = 1 for the next cycle only; state -> IDLE.
- Latency: start sampled at edge k; done is high in the cycle following edge k+DATA_W+1, i.e. 34 clocks for DATA_W=32. Latency is constant, with no early-out for small or zero operands.
- div_busy: 1 in CALC and FIXUP; 0 in the done cycle and in IDLE.
- E_div_start while busy is ignored; the latched operands are not disturbed.
- Start and done in the same cycle: done comes from the previous operation, and the new start is accepted because the state is IDLE.
- A_flush in CALC or FIXUP: next state is IDLE, busy=0, no done pulse, and outputs keep their previous values.
- A_flush together with E_div_start in IDLE: flush wins and the start is dropped.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, no flag. This falls out of the magnitude algorithm and is not special-cased.
- The subtractor is DATA_W+1 bits wide so the magnitude 0x80000000 does not overflow; negation is two's complement truncated to DATA_W.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 -> busy for cycles 1..33; done at cycle 34; quot=14, rem=2, div_by_zero=0.
- Signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
- Signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0. Same operands unsigned -> quot=0, rem=0x80000000.
- Divide by zero, unsigned and signed, 0x00001234 / 0 -> quot=0xFFFFFFFF, rem=0x00001234, div_by_zero=1, done still at 34 cycles. A following 9/3 must clear div_by_zero (quot=3, rem=0).
- Start pulsed again at cycle 5 with different operands -> ignored; the original result is produced at cycle 34. Back-to-back start in the done cycle -> the second result is produced 34 cycles later.
- A_flush at cycle 10 -> busy=0 from cycle 11, no done ever, outputs unchanged. Reset asserted at cycle 20 of a new divide -> all outputs 0 the next cycle, and a fresh 100/7 then completes normally.
